// File: rtl/core_decode_mult_seq.sv
// LDM/STM micro-op sequencer between fetch queue and decode mux.
// Optional DECODE_MULT_SEQ_PERF_EN adds perf_uops/perf_stalls counters.
module core_decode_mult_seq #(
  parameter int NUM_REGS   = 16,
  parameter int WORD_BYTES = 4,
  parameter int OFF_W      = $clog2(NUM_REGS*WORD_BYTES)+2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_insn,
  input  logic                        in_is_mult,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_insn,
  output logic [$clog2(NUM_REGS)-1:0] out_reg,
  output logic [OFF_W-1:0]            out_offset,
  output logic [OFF_W-1:0]            out_wb_delta,
  output logic                        out_first,
  output logic                        out_last,
  output logic                        out_mult,
  output logic                        out_undefined
`ifdef DECODE_MULT_SEQ_PERF_EN
  ,
  output logic [31:0]                 perf_uops,
  output logic [31:0]                 perf_stalls
`endif
);

  localparam int RW = $clog2(NUM_REGS);
  localparam int CW = $clog2(NUM_REGS+1);
  localparam logic signed [OFF_W-1:0] STEP = OFF_W'(WORD_BYTES);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t state_q, state_d;
  logic [NUM_REGS-1:0] mask_q;

  logic accept, hs;
  logic [NUM_REGS-1:0] list, list_rest, mask_rest;
  logic [CW-1:0] cnt;
  logic signed [OFF_W-1:0] n_bytes, base_off, wb_delta;
  logic p_bit, u_bit;

  function automatic logic [RW-1:0] lowest(input logic [NUM_REGS-1:0] m);
    lowest = '0;
    for (int i = NUM_REGS-1; i >= 0; i--)
      if (m[i]) lowest = RW'(i);
  endfunction

  assign accept = in_valid && in_ready;
  assign hs     = out_valid && out_ready;

  assign list      = in_insn[NUM_REGS-1:0];
  assign p_bit     = in_insn[24];
  assign u_bit     = in_insn[23];
  assign list_rest = list & (list - NUM_REGS'(1));
  assign mask_rest = mask_q & (mask_q - NUM_REGS'(1));

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      cnt = cnt + CW'(list[i]);
  end

  // Descending lists still start at the lowest address
  always_comb begin
    n_bytes  = OFF_W'(cnt) * STEP;
    base_off = '0;
    wb_delta = '0;
    if (u_bit) begin
      base_off = p_bit ? STEP : '0;
      wb_delta = n_bytes;
    end else begin
      base_off = -n_bytes + (p_bit ? '0 : STEP);
      wb_delta = -n_bytes;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:
          if (accept && in_is_mult && cnt > CW'(1))
            state_d = EXPAND;
        EXPAND:
          if (hs && mask_rest == '0)
            state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (state_q == IDLE) && (!out_valid || out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q        <= '0;
      out_valid     <= 1'b0;
      out_insn      <= '0;
      out_reg       <= '0;
      out_offset    <= '0;
      out_wb_delta  <= '0;
      out_first     <= 1'b0;
      out_last      <= 1'b0;
      out_mult      <= 1'b0;
      out_undefined <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      mask_q    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_insn  <= in_insn;
      out_first <= 1'b1;
      if (!in_is_mult) begin
        mask_q        <= '0;
        out_reg       <= '0;
        out_offset    <= '0;
        out_wb_delta  <= '0;
        out_last      <= 1'b1;
        out_mult      <= 1'b0;
        out_undefined <= 1'b0;
      end else if (cnt == '0) begin
        mask_q        <= '0;
        out_reg       <= '0;
        out_offset    <= '0;
        out_wb_delta  <= '0;
        out_last      <= 1'b1;
        out_mult      <= 1'b1;
        out_undefined <= 1'b1;
      end else begin
        mask_q        <= list_rest;
        out_reg       <= lowest(list);
        out_offset    <= base_off;
        out_wb_delta  <= wb_delta;
        out_last      <= (list_rest == '0);
        out_mult      <= 1'b1;
        out_undefined <= 1'b0;
      end
    end else if (hs) begin
      if (state_q == EXPAND) begin
        mask_q     <= mask_rest;
        out_reg    <= lowest(mask_q);
        out_offset <= out_offset + STEP;
        out_first  <= 1'b0;
        out_last   <= (mask_rest == '0);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef DECODE_MULT_SEQ_PERF_EN
  // Counters survive flush; only reset clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_uops   <= '0;
      perf_stalls <= '0;
    end else begin
      if (hs)                     perf_uops   <= perf_uops + 32'd1;
      if (out_valid && !out_ready) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_decode_mult_seq.sv
// Directed bench for core_decode_mult_seq.
// Perf counter checks compile only with DECODE_MULT_SEQ_PERF_EN.
module tb_core_decode_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic        in_is_mult;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic [3:0]  out_reg;
  logic [7:0]  out_offset;
  logic [7:0]  out_wb_delta;
  logic        out_first;
  logic        out_last;
  logic        out_mult;
  logic        out_undefined;
`ifdef DECODE_MULT_SEQ_PERF_EN
  logic [31:0] perf_uops;
  logic [31:0] perf_stalls;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  core_decode_mult_seq dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_insn(in_insn),
    .in_is_mult(in_is_mult),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_insn(out_insn),
    .out_reg(out_reg),
    .out_offset(out_offset),
    .out_wb_delta(out_wb_delta),
    .out_first(out_first),
    .out_last(out_last),
    .out_mult(out_mult),
    .out_undefined(out_undefined)
`ifdef DECODE_MULT_SEQ_PERF_EN
    ,
    .perf_uops(perf_uops),
    .perf_stalls(perf_stalls)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_insn = '0;
    in_is_mult = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    n_chk++; if (out_insn !== 32'h0 || out_reg !== 4'h0 || out_offset !== 8'h0)
      begin n_fail++; $display("FAIL rst_data got %h/%h/%h exp 0", out_insn, out_reg, out_offset); end
`ifdef DECODE_MULT_SEQ_PERF_EN
    n_chk++; if (perf_uops !== 32'd0) begin n_fail++; $display("FAIL rst_perf got %0d exp 0", perf_uops); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_non_mult;
    in_valid = 1'b1;
    in_insn = 32'hE0810002;
    in_is_mult = 1'b0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL nm_valid got %b exp 1", out_valid); end
    n_chk++; if ({out_first, out_last, out_mult, out_undefined} !== 4'b1100)
      begin n_fail++; $display("FAIL nm_flags got %b exp 1100", {out_first, out_last, out_mult, out_undefined}); end
    n_chk++; if (out_offset !== 8'h0 || out_reg !== 4'h0 || out_wb_delta !== 8'h0)
      begin n_fail++; $display("FAIL nm_data got %h/%h/%h exp 0", out_reg, out_offset, out_wb_delta); end
    n_chk++; if (out_insn !== 32'hE0810002) begin n_fail++; $display("FAIL nm_insn got %h exp E0810002", out_insn); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL nm_in_ready got %b exp 1", in_ready); end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nm_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_ldmia;
    logic [3:0] regs [3];
    logic [7:0] offs [3];
    logic [31:0] p0;
    regs = '{4'd1, 4'd3, 4'd5};
    offs = '{8'd0, 8'd4, 8'd8};
    p0 = 32'd0;
`ifdef DECODE_MULT_SEQ_PERF_EN
    p0 = perf_uops;
`endif
    in_valid = 1'b1;
    in_insn = 32'hE8B0002A;
    in_is_mult = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (out_valid !== 1'b1 || out_reg !== regs[k] || out_offset !== offs[k])
        begin n_fail++; $display("FAIL ldm_uop%0d got v%b r%0d o%h exp r%0d o%h", k, out_valid, out_reg, out_offset, regs[k], offs[k]); end
      n_chk++; if (out_first !== (k == 0) || out_last !== (k == 2) || out_mult !== 1'b1)
        begin n_fail++; $display("FAIL ldm_flags%0d got f%b l%b m%b", k, out_first, out_last, out_mult); end
      n_chk++; if (in_ready !== (k == 2))
        begin n_fail++; $display("FAIL ldm_in_ready%0d got %b exp %b", k, in_ready, k == 2); end
      if (k == 2) begin
        n_chk++; if (out_wb_delta !== 8'd12) begin n_fail++; $display("FAIL ldm_wb got %h exp 0c", out_wb_delta); end
      end
      tick();
    end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ldm_drain got %b exp 0", out_valid); end
`ifdef DECODE_MULT_SEQ_PERF_EN
    n_chk++; if (perf_uops - p0 !== 32'd3) begin n_fail++; $display("FAIL ldm_perf got %0d exp 3", perf_uops - p0); end
`endif
  endtask

  task automatic test_stmdb;
    logic [3:0] regs [5];
    logic [7:0] offs [5];
    regs = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd14};
    offs = '{8'hEC, 8'hF0, 8'hF4, 8'hF8, 8'hFC};
    in_valid = 1'b1;
    in_insn = 32'hE92D40F0;
    in_is_mult = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (out_valid !== 1'b1 || out_reg !== regs[k] || out_offset !== offs[k])
        begin n_fail++; $display("FAIL stm_uop%0d got v%b r%0d o%h exp r%0d o%h", k, out_valid, out_reg, out_offset, regs[k], offs[k]); end
      n_chk++; if (out_last !== (k == 4))
        begin n_fail++; $display("FAIL stm_last%0d got %b exp %b", k, out_last, k == 4); end
      if (k == 4) begin
        n_chk++; if (out_wb_delta !== 8'hEC) begin n_fail++; $display("FAIL stm_wb got %h exp ec", out_wb_delta); end
      end
      tick();
    end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stm_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_stall_flush;
    in_valid = 1'b1;
    in_insn = 32'hE9B000F0;
    in_is_mult = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_reg !== 4'd4 || out_offset !== 8'd4)
      begin n_fail++; $display("FAIL sf_uop0 got r%0d o%h exp r4 o04", out_reg, out_offset); end
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++; if (out_valid !== 1'b1 || out_reg !== 4'd5 || out_offset !== 8'd8 || out_first !== 1'b0)
        begin n_fail++; $display("FAIL sf_hold%0d got v%b r%0d o%h f%b exp v1 r5 o08 f0", c, out_valid, out_reg, out_offset, out_first); end
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL sf_hold_ready%0d got %b exp 0", c, in_ready); end
    end
    out_ready = 1'b1;
    tick();
    n_chk++; if (out_reg !== 4'd6 || out_offset !== 8'd12)
      begin n_fail++; $display("FAIL sf_resume got r%0d o%h exp r6 o0c", out_reg, out_offset); end
    flush = 1'b1;
    in_valid = 1'b1;
    in_insn = 32'hE0810002;
    in_is_mult = 1'b0;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sf_flush got %b exp 0", out_valid); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sf_idle got %b exp 1", in_ready); end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sf_dropped got %b exp 0", out_valid); end
  endtask

  task automatic test_empty_b2b;
    in_valid = 1'b1;
    in_insn = 32'hE8900000;
    in_is_mult = 1'b1;
    out_ready = 1'b1;
    tick();
    n_chk++; if ({out_valid, out_undefined, out_first, out_last, out_mult} !== 5'b11111)
      begin n_fail++; $display("FAIL empty_flags got %b exp 11111", {out_valid, out_undefined, out_first, out_last, out_mult}); end
    n_chk++; if (out_offset !== 8'h0 || out_wb_delta !== 8'h0)
      begin n_fail++; $display("FAIL empty_off got %h/%h exp 0", out_offset, out_wb_delta); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL empty_ready got %b exp 1", in_ready); end
    in_insn = 32'hE0810002;
    in_is_mult = 1'b0;
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1 || out_insn !== 32'hE0810002 || out_undefined !== 1'b0 || out_mult !== 1'b0)
      begin n_fail++; $display("FAIL b2b got v%b i%h u%b m%b exp v1 iE0810002 u0 m0", out_valid, out_insn, out_undefined, out_mult); end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_async_reset;
    in_valid = 1'b1;
    in_insn = 32'hE8B0FFFF;
    in_is_mult = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_chk++; if (out_valid !== 1'b1 || out_reg !== 4'd2)
      begin n_fail++; $display("FAIL ar_pre got v%b r%0d exp v1 r2", out_valid, out_reg); end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_drop got %b exp 0", out_valid); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready got %b exp 1", in_ready); end
`ifdef DECODE_MULT_SEQ_PERF_EN
    n_chk++; if (perf_uops !== 32'd0) begin n_fail++; $display("FAIL ar_perf got %0d exp 0", perf_uops); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_chk++; if (out_valid !== 1'b0 || out_reg !== 4'd0)
      begin n_fail++; $display("FAIL ar_post got v%b r%0d exp v0 r0", out_valid, out_reg); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_post_ready got %b exp 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_non_mult();
    test_ldmia();
    test_stmdb();
    test_stall_flush();
    test_empty_b2b();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
